mc_fifo_arbiter: RTL

MC_FIFO_ARBITER -- requirements
Module: mc_fifo_arbiter

---
 rtl/mc_fifo_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mc_fifo_arbiter.sv
// C per-channel FIFOs of depth N feeding one registered output through a round-robin arbiter.
// Optional macro OVF_CNT_EN adds saturating per-channel rejected-write counters on port ovf_cnt.
module mc_fifo_arbiter #(
  parameter int K  = 4,
  parameter int N  = 4,
  parameter int C  = 4,
  parameter int AF = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C-1:0]                  wr_en,
  input  logic [C*K-1:0]                din,
  output logic [C-1:0]                  full,
  output logic [C-1:0]                  afull,
  output logic [C*($clog2(N)+1)-1:0]    count,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [K-1:0]                  m_data,
  output logic [$clog2(C)-1:0]          m_chan
`ifdef OVF_CNT_EN
  ,
  output logic [C*8-1:0]                ovf_cnt
`endif
);

  localparam int PW = $clog2(N);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(C);
  localparam logic [GW:0] C_W = (GW+1)'(C);

  logic [K-1:0]  mem    [C][N];
  logic [PW-1:0] wr_ptr [C];
  logic [PW-1:0] rd_ptr [C];
  logic [CW-1:0] cnt    [C];
  logic [GW-1:0] last_grant;

  logic [C-1:0]  nonempty;
  logic [C-1:0]  wr_acc;
  logic [C-1:0]  pop_vec;
  logic [GW-1:0] grant;
  logic          grant_found;
  logic          load;
  logic          pop;

  for (genvar g = 0; g < C; g++) begin : g_ch
    assign full[g]               = (cnt[g] == CW'(N));
    assign afull[g]              = (cnt[g] >= CW'(AF));
    assign nonempty[g]           = (cnt[g] != '0);
    assign count[g*CW +: CW]     = cnt[g];
    // full comes from the pre-edge count, so a pop in the same cycle cannot open a slot
    assign wr_acc[g]             = wr_en[g] && !full[g];
    assign pop_vec[g]            = pop && (grant == GW'(g));
  end

  assign load = !m_valid || m_ready;
  assign pop  = load && grant_found;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant       = '0;
    for (int j = 1; j <= C; j++) begin
      logic [GW:0] sum;
      sum = {1'b0, last_grant} + (GW+1)'(j);
      if (sum >= C_W) sum = sum - C_W;
      if (!grant_found && nonempty[sum[GW-1:0]]) begin
        grant_found = 1'b1;
        grant       = sum[GW-1:0];
      end
    end
  end

  // NOTE: the storage array has no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < C; i++) begin
      if (rst && wr_acc[i]) mem[i][wr_ptr[i]] <= din[i*K +: K];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < C; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_chan     <= '0;
      last_grant <= GW'(C-1);
    end else begin
      for (int i = 0; i < C; i++) begin
        if (wr_acc[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(wr_acc[i]) - CW'(pop_vec[i]);
      end
      if (load) begin
        m_valid <= grant_found;
        if (grant_found) begin
          m_data     <= mem[grant][rd_ptr[grant]];
          m_chan     <= grant;
          last_grant <= grant;
        end
      end
    end
  end

`ifdef OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else begin
      for (int i = 0; i < C; i++) begin
        if (wr_en[i] && full[i] && ovf_cnt[i*8 +: 8] != 8'hFF)
          ovf_cnt[i*8 +: 8] <= ovf_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule
